// File: rtl/mem_dp_clr.sv
// Simple-dual-port synchronous RAM with a post-reset clear engine,
// selectable read-during-write behaviour and an optional output register.
module mem_dp_clr #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BUS_WIDTH  = 14,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUS_WIDTH-1:0]  din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [BUS_WIDTH-1:0]  dout,
  output logic                  dout_vld,
  output logic                  busy
);

  localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CMP_WIDTH-1:0]  DEPTH_C   = CMP_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [ADDR_WIDTH-1:0]   clr_addr_d;
  logic                    busy_d;

  logic [BUS_WIDTH-1:0]    mem [DEPTH];

  logic                    accept_c;
  logic                    wr_ok_c;
  logic                    rd_ok_c;
  logic                    rd_in_range_c;
  logic [BUS_WIDTH-1:0]    rd_word_c;

  logic                    s1_vld;
  logic [BUS_WIDTH-1:0]    s1_data;

  // User strobes are honoured only when neither reset nor clear is active
  assign accept_c      = !rst && !busy;
  assign wr_ok_c       = accept_c && wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok_c       = accept_c && rd_en;
  assign rd_in_range_c = ({1'b0, rd_addr} < DEPTH_C);

  // Clear FSM state register; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_d;
      clr_addr <= clr_addr_d;
      busy     <= busy_d;
    end
  end

  // Clear FSM next state: one word per cycle, terminal compare at DEPTH-1
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    case (state)
      CLEAR: begin
        clr_addr_d = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Array write port: clear engine has priority, contents frozen during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok_c) begin
        mem[wr_addr] <= din;
      end
    end
  end

  // Read word selection: out-of-range reads return zero, optional write-through
  always_comb begin
    rd_word_c = '0;
    if (rd_in_range_c) begin
      if ((RDW_MODE != 0) && wr_ok_c && (wr_addr == rd_addr)) begin
        rd_word_c = din;
      end else begin
        rd_word_c = mem[rd_addr];
      end
    end
  end

  // First read stage: data holds between reads, valid pulses per accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_ok_c;
      if (rd_ok_c) begin
        s1_data <= rd_word_c;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Second read stage for latency-2 operation at full throughput
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_vld <= 1'b0;
          dout     <= '0;
        end else begin
          dout_vld <= s1_vld;
          if (s1_vld) begin
            dout <= s1_data;
          end
        end
      end
    end else begin : g_no_out_reg
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: doc/mem_dp_clr.md
Name: mem_dp_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, both on a single clock. It succeeds the single-port 256-entry memory used in the datapath. New features: independent read/write addresses, configurable depth, selectable read-during-write behaviour, optional output register, explicit read-valid strobe, and a reset-triggered clear engine that zeroes the array. Intended for line buffers and coefficient stores between datapath stages.

Parameters:
ADDR_WIDTH, 6, address bus width in bits.
BUS_WIDTH, 14, data word width in bits.
DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
RDW_MODE, 0, same-address read/write in one cycle: 0 returns old data, 1 returns din (write-through).
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
CLR_ON_RST, 1, 1 zeroes all DEPTH words after reset; 0 leaves contents undefined.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_WIDTH  write address.
din  in  BUS_WIDTH  write data.
rd_en  in  1  read strobe.
rd_addr  in  ADDR_WIDTH  read address.
dout  out  BUS_WIDTH  read data.
dout_vld  out  1  one-cycle pulse marking dout valid for one accepted read.
busy  out  1  high while reset or clear is in progress; user strobes are ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - dout <= 0, dout_vld <= 0, pipeline valid bits <= 0.
  - Clear FSM goes to CLEAR with clr_addr <= 0 if CLR_ON_RST=1; otherwise it goes to IDLE.
  - busy is 1 during every cycle rst is high, for any CLR_ON_RST.
  - Array contents are not touched while rst is high.
- Clear FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - At clr_addr = DEPTH-1, the word is written and the FSM moves to IDLE.
  - CLEAR therefore lasts exactly DEPTH cycles after rst deasserts.
  - busy is registered: busy = (state == CLEAR) or rst. It goes 0 in the first cycle the RAM accepts strobes.
- rst asserted mid-clear restarts the clear from address 0.
- While busy=1: wr_en and rd_en are ignored; no user write occurs and no dout_vld is generated.
  - Read pulses already in the OUT_REG pipeline when rst is asserted are flushed; dout_vld stays 0.
- Write: wr_en=1, not busy, wr_addr < DEPTH -> mem[wr_addr] <= din at that edge. Writes with wr_addr >= DEPTH are dropped silently.
- Read, OUT_REG=0:
  - rd_en=1 in cycle N (accepted) -> dout = data and dout_vld = 1 in cycle N+1.
  - dout_vld is 0 in any cycle without an accepted read in the previous cycle.
  - dout holds its last value when no read occurs.
- Read, OUT_REG=1: the same with one extra stage; data and dout_vld appear in cycle N+2. Back-to-back reads give back-to-back valid outputs with full throughput.
- Out-of-range read (rd_addr >= DEPTH): dout = 0 with dout_vld = 1.
- Simultaneous read and write to the same in-range address:
  - RDW_MODE=0: dout returns the pre-write contents.
  - RDW_MODE=1: dout returns din.
  - Different addresses are fully independent.
- No arithmetic beyond the clr_addr counter. clr_addr is ADDR_WIDTH wide; its terminal compare is against DEPTH-1, never against wrap-around.

Test Plan:
- Reset with CLR_ON_RST=1, DEPTH=64, rst high for 3 cycles then low -> busy=1 for 3+64 cycles, then 0. Reading addresses 0..63 afterwards returns 0 with dout_vld pulses.
- Write 0x1A5 to addr 5, then rd_en addr 5 next cycle; OUT_REG=0 -> dout=0x1A5 and dout_vld=1 exactly one cycle after rd_en. Repeat with OUT_REG=1 -> two cycles.
- After writing 0x0F0 to addr 9, same-cycle wr_en/rd_en to addr 9 with din=0x3FF -> RDW_MODE=0 returns 0x0F0, RDW_MODE=1 returns 0x3FF.
- DEPTH=48, ADDR_WIDTH=6: write 0x123 to addr 50 -> no array change; read addr 50 -> dout=0, dout_vld=1. Reads of addrs 0..47 are unchanged.
- Pulse rst for 1 cycle at clear cycle 30 -> clear restarts at addr 0 and busy stays high for 64 more cycles. Strobes issued while busy produce no writes and no dout_vld.
- Continuous rd_en for 16 cycles over addrs 0..15 pre-written with a+0x100, OUT_REG=1 -> 16 consecutive dout_vld cycles carrying 0x100..0x10F in order.
